// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
// Holds the game_status codes, direction codes, the opposite-direction helper
// and the default step-period constants. Used by the movement scheduler, the
// game control unit and the snake body logic.
package snake_pkg;

  typedef enum logic [1:0] {
    GsRestart = 2'b00,
    GsStart   = 2'b01,
    GsPlay    = 2'b10,
    GsDie     = 2'b11
  } game_status_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned DEFAULT_TICK_DIV   = 32'd12_500_000;
  localparam int unsigned DEFAULT_SPEED_STEP = 32'd1_000_000;
  localparam int unsigned DEFAULT_MIN_DIV    = 32'd2_500_000;

  // UP/DOWN and LEFT/RIGHT differ only in the LSB.
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Two-entry direction request queue.
// Picks one key per cycle (key1 > key2 > key3 > key4), drops requests that
// repeat or reverse the reference heading (queue tail, or cur_dir when empty),
// and accepts a push into a full queue when a pop happens on the same edge.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             empty the queue (RESTART / DIE)
//   push_en           key requests may be enqueued this cycle
//   key1..key4        one-cycle key pulses (UP, DOWN, LEFT, RIGHT)
//   pop               remove the head this cycle (ignored when empty)
//   cur_dir           current heading, used as reference when empty
//   head              oldest queued direction
//   not_empty, full   occupancy flags
module dir_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push_en,
  input  logic       key1,
  input  logic       key2,
  input  logic       key3,
  input  logic       key4,
  input  logic       pop,
  input  logic [1:0] cur_dir,
  output logic [1:0] head,
  output logic       not_empty,
  output logic       full
);

  logic [1:0] entry0_q, entry1_q;
  logic [1:0] count_q;
  logic       key_valid;
  logic [1:0] key_dir;
  logic [1:0] ref_dir;
  logic       pop_ok;
  logic       accept;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_UP;
    if (key1)      key_dir = DIR_UP;
    else if (key2) key_dir = DIR_DOWN;
    else if (key3) key_dir = DIR_LEFT;
    else if (key4) key_dir = DIR_RIGHT;
    else           key_valid = 1'b0;
  end

  always_comb begin
    ref_dir = cur_dir;
    if (count_q == 2'd1)      ref_dir = entry0_q;
    else if (count_q == 2'd2) ref_dir = entry1_q;
  end

  assign not_empty = (count_q != 2'd0);
  assign full      = (count_q == 2'd2);
  assign head      = entry0_q;
  assign pop_ok    = pop & not_empty;
  assign accept    = push_en & key_valid & (key_dir != ref_dir) &
                     (key_dir != dir_opposite(ref_dir)) & (~full | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_q <= DIR_UP;
      entry1_q <= DIR_UP;
      count_q  <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({pop_ok, accept})
        2'b10: begin
          entry0_q <= entry1_q;
          count_q  <= count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) entry0_q <= key_dir;
          else                 entry1_q <= key_dir;
          count_q <= count_q + 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: shift and append behind the survivor.
          if (count_q == 2'd1) begin
            entry0_q <= key_dir;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= key_dir;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snake_move_sched.sv
// Snake movement scheduler.
// Generates the one-cycle move_tick step strobe, owns the current heading and
// shortens the step period on every eat pulse, all gated by game_status.
// Optional feature macro: PAUSE_SCHED_EN adds pause_press input and paused
// output; while paused in PLAY the counter freezes, keys are ignored and eat
// still shortens the period.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   game_status          00 RESTART, 01 START, 10 PLAY, 11 DIE
//   key1..key4           one-cycle requests UP, DOWN, LEFT, RIGHT
//   eat                  one-cycle pulse, head reached food
//   move_tick            one-cycle step strobe
//   dir                  current heading (valid for the step while move_tick=1)
//   step_div             current step period in clk cycles
//   queue_full           direction queue holds two entries
module snake_move_sched
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int unsigned SPEED_STEP = DEFAULT_SPEED_STEP,
  parameter int unsigned MIN_DIV    = DEFAULT_MIN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_status,
  input  logic        key1,
  input  logic        key2,
  input  logic        key3,
  input  logic        key4,
  input  logic        eat,
`ifdef PAUSE_SCHED_EN
  input  logic        pause_press,
  output logic        paused,
`endif
  output logic        move_tick,
  output logic [1:0]  dir,
  output logic [31:0] step_div,
  output logic        queue_full
);

  game_status_e gs;
  logic [31:0]  cnt_q;
  logic         move_tick_q;
  logic [1:0]   dir_q;
  logic [31:0]  step_div_q;
  logic [31:0]  step_div_eat;
  logic         sched_paused;
  logic         in_play;
  logic         running;
  logic         period_end;
  logic         q_pop;
  logic         q_flush;
  logic         q_push_en;
  logic [1:0]   q_head;
  logic         q_not_empty;

  assign gs      = game_status_e'(game_status);
  assign in_play = (gs == GsPlay);
  assign running = in_play & ~sched_paused;

  // ">=" rather than "==" so a period shortened below cnt+1 ticks at once
  // instead of running the counter through 2^32. step_div is never below 2.
  assign period_end = (cnt_q >= step_div_q - 32'd1);
  assign q_pop      = running & period_end;
  assign q_flush    = (gs == GsRestart) | (gs == GsDie);
  assign q_push_en  = (gs == GsStart) | running;

  // Saturating subtract, compared in 33 bits so MIN_DIV+SPEED_STEP cannot wrap.
  assign step_div_eat = ({1'b0, step_div_q} >= 33'(MIN_DIV) + 33'(SPEED_STEP)) ?
                        step_div_q - 32'(SPEED_STEP) : 32'(MIN_DIV);

`ifdef PAUSE_SCHED_EN
  logic paused_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              paused_q <= 1'b0;
    else if (!in_play)    paused_q <= 1'b0;
    else if (pause_press) paused_q <= ~paused_q;
  end

  assign sched_paused = paused_q;
  assign paused       = paused_q;
`else
  assign sched_paused = 1'b0;
`endif

  dir_queue u_dir_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (q_flush),
    .push_en   (q_push_en),
    .key1      (key1),
    .key2      (key2),
    .key3      (key3),
    .key4      (key4),
    .pop       (q_pop),
    .cur_dir   (dir_q),
    .head      (q_head),
    .not_empty (q_not_empty),
    .full      (queue_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 32'd0;
      move_tick_q <= 1'b0;
      dir_q       <= DIR_RIGHT;
      step_div_q  <= 32'(TICK_DIV);
    end else begin
      move_tick_q <= 1'b0;
      case (gs)
        GsRestart: begin
          cnt_q      <= 32'd0;
          dir_q      <= DIR_RIGHT;
          step_div_q <= 32'(TICK_DIV);
        end
        GsStart: begin
          cnt_q <= 32'd0;
        end
        GsPlay: begin
          if (eat) step_div_q <= step_div_eat;
          if (!sched_paused) begin
            if (period_end) begin
              cnt_q       <= 32'd0;
              move_tick_q <= 1'b1;
              if (q_not_empty) dir_q <= q_head;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
        default: ;  // DIE: everything held, queue flushed
      endcase
    end
  end

  assign move_tick = move_tick_q;
  assign dir       = dir_q;
  assign step_div  = step_div_q;

endmodule

// File: tb/tb_snake_move_sched.sv
module tb_snake_move_sched;

  localparam int unsigned TD = 10;
  localparam int unsigned SS = 3;
  localparam int unsigned MD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  game_status;
  logic        key1, key2, key3, key4, eat;
  logic        move_tick;
  logic [1:0]  dir;
  logic [31:0] step_div;
  logic        queue_full;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of requested headings, current heading, period,
  // cycles elapsed in the current period.
  logic [1:0]  mq[$];
  logic [1:0]  m_dir;
  logic [31:0] m_div;
  longint      m_cnt;
  logic        m_tick;

  always #5 clk = ~clk;

  snake_move_sched #(
    .TICK_DIV   (TD),
    .SPEED_STEP (SS),
    .MIN_DIV    (MD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_status (game_status),
    .key1        (key1),
    .key2        (key2),
    .key3        (key3),
    .key4        (key4),
    .eat         (eat),
    .move_tick   (move_tick),
    .dir         (dir),
    .step_div    (step_div),
    .queue_full  (queue_full)
  );

  task automatic model_reset();
    mq.delete();
    m_dir  = 2'b11;
    m_div  = TD;
    m_cnt  = 0;
    m_tick = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [1:0] cand, refd;
    bit         have, accept, over;
    longint     d;
    have = 1'b1;
    cand = 2'b00;
    if (key1)      cand = 2'b00;
    else if (key2) cand = 2'b01;
    else if (key3) cand = 2'b10;
    else if (key4) cand = 2'b11;
    else           have = 1'b0;
    refd   = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
    m_tick = 1'b0;
    case (game_status)
      2'b00: begin
        m_cnt = 0; mq.delete(); m_dir = 2'b11; m_div = TD;
      end
      2'b01: begin
        m_cnt  = 0;
        accept = have && cand != refd && cand != (refd ^ 2'b01) && mq.size() < 2;
        if (accept) mq.push_back(cand);
      end
      2'b10: begin
        over   = (m_cnt + 1 >= longint'(m_div));
        accept = have && cand != refd && cand != (refd ^ 2'b01) &&
                 (mq.size() < 2 || (over && mq.size() > 0));
        if (over) begin
          m_cnt  = 0;
          m_tick = 1'b1;
          if (mq.size() > 0) m_dir = mq.pop_front();
        end else begin
          m_cnt = m_cnt + 1;
        end
        if (accept) mq.push_back(cand);
        if (eat) begin
          d     = longint'(m_div) - longint'(SS);
          m_div = (d < longint'(MD)) ? MD : 32'(d);
        end
      end
      default: mq.delete();
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    {key1, key2, key3, key4, eat} = 5'b0;
  endtask

  task automatic restart_then_play();
    game_status = 2'b00;
    cycle();
    game_status = 2'b10;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    game_status = 2'b00;
    {key1, key2, key3, key4, eat} = 5'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (move_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", move_tick); end
    n_tests++;
    if (dir !== 2'b11) begin n_fail++; $display("FAIL reset_dir got=%b exp=11", dir); end
    n_tests++;
    if (step_div !== TD) begin n_fail++; $display("FAIL reset_div got=%0d exp=%0d", step_div, TD); end
    n_tests++;
    if (queue_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", queue_full); end
    rst = 1'b0;
  endtask

  task automatic test_period();
    restart_then_play();
    for (int i = 1; i <= 35; i++) begin
      cycle();
      n_tests++;
      if (move_tick !== (i % 10 == 0) || dir !== 2'b11) begin
        n_fail++;
        $display("FAIL period cyc=%0d tick=%b dir=%b exp tick=%b dir=11", i, move_tick, dir,
                 (i % 10 == 0));
      end
    end
  endtask

  task automatic test_keys();
    logic [1:0] ed;
    restart_then_play();
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) key1 = 1'b1;
      if (i == 4) key3 = 1'b1;
      cycle();
      ed = (i < 10) ? 2'b11 : (i < 20) ? 2'b00 : 2'b10;
      n_tests++;
      if (move_tick !== (i % 10 == 0) || dir !== ed || queue_full !== (i >= 4 && i < 10)) begin
        n_fail++;
        $display("FAIL keys cyc=%0d tick=%b dir=%b full=%b exp tick=%b dir=%b full=%b", i,
                 move_tick, dir, queue_full, (i % 10 == 0), ed, (i >= 4 && i < 10));
      end
    end
  endtask

  task automatic test_filter();
    logic [1:0] ed;
    restart_then_play();
    for (int i = 1; i <= 21; i++) begin
      if (i == 2) key3 = 1'b1;
      if (i == 3) begin key1 = 1'b1; key2 = 1'b1; end
      cycle();
      ed = (i < 10) ? 2'b11 : 2'b00;
      n_tests++;
      if (dir !== ed || queue_full !== 1'b0) begin
        n_fail++;
        $display("FAIL filter cyc=%0d dir=%b full=%b exp dir=%b full=0", i, dir, queue_full, ed);
      end
    end
  endtask

  task automatic test_eat();
    logic [31:0] ediv;
    logic        et;
    restart_then_play();
    for (int i = 1; i <= 33; i++) begin
      if (i == 8 || i == 17 || i == 21) eat = 1'b1;
      cycle();
      ediv = (i < 8) ? 32'd10 : (i < 17) ? 32'd7 : 32'd4;
      et   = (i == 9 || i == 16 || i == 20 || i == 24 || i == 28 || i == 32);
      n_tests++;
      if (step_div !== ediv || move_tick !== et) begin
        n_fail++;
        $display("FAIL eat cyc=%0d div=%0d tick=%b exp div=%0d tick=%b", i, step_div, move_tick,
                 ediv, et);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] ed;
    restart_then_play();
    for (int i = 1; i <= 30; i++) begin
      if (i == 2 || i == 10) key1 = 1'b1;
      if (i == 3) key3 = 1'b1;
      cycle();
      ed = (i < 10) ? 2'b11 : (i < 20) ? 2'b00 : (i < 30) ? 2'b10 : 2'b00;
      n_tests++;
      if (dir !== ed || queue_full !== (i >= 3 && i < 20)) begin
        n_fail++;
        $display("FAIL fullpush cyc=%0d dir=%b full=%b exp dir=%b full=%b", i, dir, queue_full,
                 ed, (i >= 3 && i < 20));
      end
    end
  endtask

  task automatic test_status();
    restart_then_play();
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) key1 = 1'b1;
      if (i == 3) eat = 1'b1;
      if (i == 8) key3 = 1'b1;
      cycle();
    end
    n_tests++;
    if (dir !== 2'b00 || step_div !== 32'd7 || queue_full !== 1'b0) begin
      n_fail++;
      $display("FAIL status_play dir=%b div=%0d full=%b exp dir=00 div=7 full=0", dir, step_div,
               queue_full);
    end
    game_status = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      key2 = i[0];
      eat  = i[1];
      cycle();
      n_tests++;
      if (move_tick !== 1'b0 || dir !== 2'b00 || step_div !== 32'd7 || queue_full !== 1'b0) begin
        n_fail++;
        $display("FAIL status_die cyc=%0d tick=%b dir=%b div=%0d full=%b", i, move_tick, dir,
                 step_div, queue_full);
      end
    end
    game_status = 2'b00;
    for (int i = 1; i <= 2; i++) begin
      cycle();
      n_tests++;
      if (move_tick !== 1'b0 || dir !== 2'b11 || step_div !== TD || queue_full !== 1'b0) begin
        n_fail++;
        $display("FAIL status_restart tick=%b dir=%b div=%0d full=%b", move_tick, dir, step_div,
                 queue_full);
      end
    end
    game_status = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_tests++;
      if (move_tick !== 1'b0) begin n_fail++; $display("FAIL status_start tick=%b exp=0", move_tick); end
    end
    game_status = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      n_tests++;
      if (move_tick !== (i == 10) || dir !== 2'b11) begin
        n_fail++;
        $display("FAIL status_resume cyc=%0d tick=%b dir=%b exp tick=%b dir=11", i, move_tick,
                 dir, (i == 10));
      end
    end
  endtask

  task automatic test_async_reset();
    restart_then_play();
    for (int i = 1; i <= 7; i++) begin
      if (i == 2 || i == 7) key1 = 1'b1;
      if (i == 3) eat = 1'b1;
      if (i == 5) key3 = 1'b1;
      cycle();
    end
    n_tests++;
    if (move_tick !== 1'b1 || dir !== 2'b00 || step_div !== 32'd7 || queue_full !== 1'b1) begin
      n_fail++;
      $display("FAIL prereset tick=%b dir=%b div=%0d full=%b exp 1/00/7/1", move_tick, dir,
               step_div, queue_full);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (move_tick !== 1'b0 || dir !== 2'b11 || step_div !== TD || queue_full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset tick=%b dir=%b div=%0d full=%b exp 0/11/%0d/0", move_tick, dir,
               step_div, queue_full, TD);
    end
    game_status = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int r;
    restart_then_play();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        game_status = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
      end
      key1 = ($urandom_range(0, 7) == 0);
      key2 = ($urandom_range(0, 7) == 0);
      key3 = ($urandom_range(0, 7) == 0);
      key4 = ($urandom_range(0, 7) == 0);
      eat  = ($urandom_range(0, 24) == 0);
      cycle();
      n_tests++;
      if (move_tick !== m_tick || dir !== m_dir || step_div !== m_div ||
          queue_full !== (mq.size() == 2)) begin
        n_fail++;
        $display("FAIL random cyc=%0d got tick=%b dir=%b div=%0d full=%b exp tick=%b dir=%b div=%0d full=%b",
                 i, move_tick, dir, step_div, queue_full, m_tick, m_dir, m_div, (mq.size() == 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_keys();
    test_filter();
    test_eat();
    test_full_push_pop();
    test_status();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
